// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_W data bits, optional parity, 1/2 stop bits,
// one-entry holding buffer for gapless back-to-back frames. One bit per clk_baud cycle.
module uart_tx_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk_baud,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              take_direct;
    logic              load;
    logic [DATA_W-1:0] load_word;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        accept      = tx_valid && !buf_full_q;
        take_direct = 1'b0;
        load        = 1'b0;
        load_word   = tx_data;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    take_direct = 1'b1;
                    load        = 1'b1;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = (PARITY != 0) ? StParity : StStop;
                    cnt_d   = '0;
                end else begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                state_d = StStop;
                cnt_d   = '0;
            end
            StStop: begin
                if (cnt_q == CntW'(STOP_BITS - 1)) begin
                    state_d = StIdle;
                    if (buf_full_q) begin
                        load       = 1'b1;
                        load_word  = buf_q;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        // Line is freeing up this edge: start the new word without parking it.
                        take_direct = 1'b1;
                        load        = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StStart;
            shreg_d = load_word;
            par_d   = (PARITY == 2) ? ^load_word : ~^load_word;
        end

        if (accept && !take_direct) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        // Outputs are registered copies of what the next state drives onto the line.
        unique case (state_d)
            StStart:  ser_d = 1'b0;
            StData:   ser_d = shreg_d[0];
            StParity: ser_d = par_d;
            default:  ser_d = 1'b1;
        endcase
        done_d = (state_d == StStop) && (cnt_d == CntW'(STOP_BITS - 1));
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ser_q      <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ser_q      <= ser_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready   = ~buf_full_q;
    assign serial_out = ser_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: six parameter variants share one stimulus stream and are
// checked every cycle against a frame-level bit-stream model, plus literal frame checks.
module tb_uart_tx_param;

    localparam int NI = 6;
    localparam int CDW  [NI] = '{8, 8, 8, 7, 5, 9};
    localparam int CPAR [NI] = '{0, 2, 1, 1, 2, 1};
    localparam int CSB  [NI] = '{1, 1, 1, 2, 2, 1};

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [8:0] data  = '0;
    logic       valid = 1'b0;
    logic [NI-1:0] ser, rdy, bsy, dn;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_baud(clk), .rst(rst), .tx_data(data[7:0]), .tx_valid(valid),
        .tx_ready(rdy[0]), .serial_out(ser[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk_baud(clk), .rst(rst), .tx_data(data[7:0]), .tx_valid(valid),
        .tx_ready(rdy[1]), .serial_out(ser[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk_baud(clk), .rst(rst), .tx_data(data[7:0]), .tx_valid(valid),
        .tx_ready(rdy[2]), .serial_out(ser[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_param #(.DATA_W(7), .PARITY(1), .STOP_BITS(2)) u3 (
        .clk_baud(clk), .rst(rst), .tx_data(data[6:0]), .tx_valid(valid),
        .tx_ready(rdy[3]), .serial_out(ser[3]), .busy(bsy[3]), .tx_done(dn[3]));
    uart_tx_param #(.DATA_W(5), .PARITY(2), .STOP_BITS(2)) u4 (
        .clk_baud(clk), .rst(rst), .tx_data(data[4:0]), .tx_valid(valid),
        .tx_ready(rdy[4]), .serial_out(ser[4]), .busy(bsy[4]), .tx_done(dn[4]));
    uart_tx_param #(.DATA_W(9), .PARITY(1), .STOP_BITS(1)) u5 (
        .clk_baud(clk), .rst(rst), .tx_data(data[8:0]), .tx_valid(valid),
        .tx_ready(rdy[5]), .serial_out(ser[5]), .busy(bsy[5]), .tx_done(dn[5]));

    // Model: each variant has at most one frame on the line (word + bit position) and one
    // parked word.
    int         pos  [NI];
    logic [8:0] cur  [NI];
    logic       bufv [NI];
    logic [8:0] bufw [NI];

    function automatic int flen(int i);
        return 1 + CDW[i] + ((CPAR[i] != 0) ? 1 : 0) + CSB[i];
    endfunction

    function automatic logic fbit(int i, logic [8:0] w, int k);
        logic [8:0] m;
        m = w & ~(9'h1FF << CDW[i]);
        if (k == 0) return 1'b0;
        if (k <= CDW[i]) return m[k-1];
        if (CPAR[i] != 0 && k == CDW[i] + 1) return (CPAR[i] == 2) ? ^m : ~^m;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_line(int i, logic [8:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < flen(i); k++) r[k] = fbit(i, w, k);
        return r;
    endfunction

    initial begin
        for (int i = 0; i < NI; i++) begin
            pos[i] = -1; bufv[i] = 1'b0; cur[i] = '0; bufw[i] = '0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    pos[i] = -1;
                    bufv[i] = 1'b0;
                end else begin
                    logic acc;
                    acc = valid && !bufv[i];
                    if (pos[i] >= 0) begin
                        pos[i]++;
                        if (pos[i] == flen(i)) pos[i] = -1;
                    end
                    if (pos[i] < 0) begin
                        if (bufv[i]) begin
                            cur[i] = bufw[i]; pos[i] = 0; bufv[i] = 1'b0;
                        end else if (acc) begin
                            cur[i] = data; pos[i] = 0;
                        end
                    end else if (acc) begin
                        bufw[i] = data; bufv[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                logic [3:0] want, got;
                if (pos[i] < 0) want = {1'b1, 1'b0, 1'b0, ~bufv[i]};
                else want = {fbit(i, cur[i], pos[i]), 1'b1, (pos[i] == flen(i) - 1), ~bufv[i]};
                got = {ser[i], bsy[i], dn[i], rdy[i]};
                compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL cycle_u%0d t=%0t: {ser,busy,done,ready} got %b want %b",
                             i, $time, got, want);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    logic [31:0] cs [NI];
    logic [31:0] cd [NI];
    logic [31:0] cb [NI];
    logic [31:0] cr [NI];

    // Capture 24 cycles of every output starting at the acceptance edge of w0.
    task automatic send(input logic [8:0] w0, input logic [8:0] w1, input bit two);
        @(negedge clk);
        data  = w0;
        valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                cs[i][k] = ser[i]; cd[i][k] = dn[i]; cb[i][k] = bsy[i]; cr[i][k] = rdy[i];
            end
            if (k == 0 && two) data = w1;
            else valid = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        rst = 1'b1;
        #1;
        chk("rst_idle_out", {ser, rdy, bsy, dn}, {6'h3F, 6'h3F, 6'h00, 6'h00});
        @(negedge clk) rst = 1'b0;

        chk("model_99_8n1",  model_line(0, 9'h099), 32'h332);
        chk("model_62_even", model_line(1, 9'h062), 32'h6C4);
        chk("model_62_odd",  model_line(2, 9'h062), 32'h4C4);
        chk("model_55_7o2",  model_line(3, 9'h055), 32'h7AA);

        send(9'h099, 9'h000, 1'b0);
        chk("line_99_8n1", cs[0][9:0], 32'h332);
        chk("done_99_8n1", cd[0][23:0], 32'h200);
        chk("busy_99_8n1", cb[0][10:0], 32'h3FF);

        send(9'h062, 9'h000, 1'b0);
        chk("line_62_even", cs[1][10:0], 32'h6C4);
        chk("line_62_odd",  cs[2][10:0], 32'h4C4);
        chk("done_62_even", cd[1][23:0], 32'h400);

        send(9'h055, 9'h000, 1'b0);
        chk("line_55_7o2",  cs[3][10:0], 32'h7AA);
        chk("done_55_7o2",  cd[3][23:0], 32'h400);
        chk("busy_55_7o2",  cb[3][11:0], 32'h7FF);
        chk("line_15_5e2",  cs[4][8:0],  32'h1EA);
        chk("line_055_9o1", cs[5][11:0], 32'hCAA);

        send(9'h0A5, 9'h03C, 1'b1);
        chk("line_b2b",  cs[0][23:0], 32'hF9E34A);
        chk("busy_b2b",  cb[0][20:0], 32'h0FFFFF);
        chk("done_b2b",  cd[0][23:0], 32'h080200);
        chk("ready_b2b", cr[0][10:0], 32'h401);

        @(negedge clk);
        data  = 9'h1C3;
        valid = 1'b1;
        @(negedge clk) valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_frame_out", {ser, rdy, bsy, dn}, {6'h3F, 6'h3F, 6'h00, 6'h00});
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);

        // Backpressure: valid held, data changing every cycle.
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            valid = 1'b1;
            data  = 9'($urandom);
        end

        for (int blk = 0; blk < 20; blk++) begin
            int prob;
            prob = (blk % 4 == 0) ? 100 : (blk % 4 == 1) ? 30 : (blk % 4 == 2) ? 0 : 75;
            for (int n = 0; n < 150; n++) begin
                @(negedge clk);
                valid = ($urandom_range(0, 99) < prob);
                data  = 9'($urandom);
            end
        end

        @(negedge clk) valid = 1'b0;
        repeat (30) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
